// File: rtl/rvga_debugtrace_buf.sv
// rvga_debugtrace_buf
//
// Debug trace buffer for decoded instructions. It records {pc, opcode,
// inst_type, subop} for each valid instruction into a circular buffer while
// armed. When the trigger instruction arrives, it keeps recording for
// POST_TRIG more instructions and then freezes. The frozen contents drain
// oldest-first through a valid/ready readout port.
//
// Optional feature (macro RVGA_TRACE_TIMESTAMP_EN):
//   defined   - a free-running 16-bit cycle counter is appended as the record
//               LSBs, so RECW = PCW + 30
//   undefined - no counter, so RECW = PCW + 14
//
// Parameters:
//   DEPTH      trace entries (power of two, >= 2)
//   PCW        width of the captured PC field
//   POST_TRIG  entries recorded after the trigger entry (0..DEPTH-1)
//
// Ports:
//   clk_i          clock; all state changes on its rising edge
//   rst_ni         asynchronous reset, active-low
//   valid_i        a decoded instruction is presented this cycle
//   pc_i           PC of the instruction
//   opcode_i       decoded opcode
//   inst_type_i    decoded instruction type
//   subop_i        selected brop/ldop/strop/artop code
//   arm_i          pulse: clear the buffer and start a capture
//   abort_i        pulse: clear the buffer and go idle (overflow is held)
//   trig_en_i      1: trigger on opcode match; 0: first valid instruction
//   trig_opcode_i  opcode to match
//   rd_ready_i     readout consumer accepts data
//   rd_valid_o     rd_data_o holds the oldest entry (DONE only)
//   rd_data_o      oldest record, 0 while the buffer is empty
//   state_o        IDLE=0, ARMED=1, CAPTURE=2, DONE=3
//   count_o        number of valid entries
//   overflow_o     sticky: an unread entry was overwritten
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | nothing recorded; waiting for arm_i
// ARMED    | recording every valid instruction; looking for the trigger
// CAPTURE  | trigger seen; recording POST_TRIG more instructions
// DONE     | frozen; draining entries through the readout port

module rvga_debugtrace_buf #(
    parameter int DEPTH     = 16,
    parameter int PCW       = 32,
    parameter int POST_TRIG = 4,
`ifdef RVGA_TRACE_TIMESTAMP_EN
    localparam int TSW      = 16,
`else
    localparam int TSW      = 0,
`endif
    localparam int RECW     = PCW + 14 + TSW,
    localparam int CNTW     = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [PCW-1:0]  pc_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      inst_type_i,
    input  logic [3:0]      subop_i,
    input  logic            arm_i,
    input  logic            abort_i,
    input  logic            trig_en_i,
    input  logic [6:0]      trig_opcode_i,
    input  logic            rd_ready_i,
    output logic            rd_valid_o,
    output logic [RECW-1:0] rd_data_o,
    output logic [1:0]      state_o,
    output logic [CNTW-1:0] count_o,
    output logic            overflow_o
);

    localparam int PTRW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [PTRW-1:0] wptr_q, rptr_q;
    logic [PTRW-1:0] post_q, post_d;
    logic [CNTW-1:0] count_q;
    logic            overflow_q;

    logic            clr;
    logic            clr_ovf;
    logic            wr_en;
    logic            pop;
    logic            full;
    logic            empty;
    logic            trig_hit;
    logic [RECW-1:0] wr_rec;

    logic [RECW-1:0] mem [DEPTH];

    assign full     = (count_q == CNTW'(DEPTH));
    assign empty    = (count_q == '0);
    assign trig_hit = !trig_en_i || (opcode_i == trig_opcode_i);

`ifdef RVGA_TRACE_TIMESTAMP_EN
    logic [15:0] ts_q;

    // Free-running; wraps naturally at 65535 -> 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 16'd1;
        end
    end

    assign wr_rec = {pc_i, opcode_i, inst_type_i, subop_i, ts_q};
`else
    assign wr_rec = {pc_i, opcode_i, inst_type_i, subop_i};
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            post_q  <= '0;
        end else begin
            state_q <= state_d;
            post_q  <= post_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath strobes.
    // abort_i outranks arm_i, and both outrank anything the current state
    // would do, so an instruction presented alongside arm_i is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        post_d  = post_q;
        clr     = 1'b0;
        clr_ovf = 1'b0;
        wr_en   = 1'b0;
        pop     = 1'b0;

        if (abort_i) begin
            clr     = 1'b1;
            post_d  = '0;
            state_d = ST_IDLE;
        end else if (arm_i) begin
            clr     = 1'b1;
            clr_ovf = 1'b1;
            post_d  = '0;
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (valid_i) begin
                        wr_en = 1'b1;
                        if (trig_hit) begin
                            if (POST_TRIG == 0) begin
                                state_d = ST_DONE;
                            end else begin
                                post_d  = PTRW'(POST_TRIG);
                                state_d = ST_CAPTURE;
                            end
                        end
                    end
                end
                ST_CAPTURE: begin
                    // Post-trigger down-counter; terminal count is the
                    // write that takes it from 1 to 0.
                    if (valid_i) begin
                        wr_en  = 1'b1;
                        post_d = post_q - PTRW'(1);
                        if (post_q == PTRW'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_valid_o && rd_ready_i) begin
                        pop = 1'b1;
                        if (count_q == CNTW'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and overflow flag.
    // Pointers are PTRW bits wide and DEPTH is a power of two, so the
    // increment wraps modulo DEPTH without extra logic.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end else if (wr_en) begin
            wptr_q <= wptr_q + PTRW'(1);
            if (full) begin
                // The write lands on the oldest entry; drop it from the
                // read side so the buffer keeps the newest DEPTH records.
                rptr_q     <= rptr_q + PTRW'(1);
                overflow_q <= 1'b1;
            end else begin
                count_q <= count_q + CNTW'(1);
            end
        end else if (pop) begin
            rptr_q  <= rptr_q + PTRW'(1);
            count_q <= count_q - CNTW'(1);
        end
    end

    // Storage is not reset; the read mux masks it while the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wptr_q] <= wr_rec;
        end
    end

    assign rd_valid_o = (state_q == ST_DONE) && !empty;
    assign rd_data_o  = empty ? '0 : mem[rptr_q];
    assign state_o    = state_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_rvga_debugtrace_buf.sv
// Testbench for rvga_debugtrace_buf.
// A reference model (queue of expected records plus state/overflow) is
// updated as each cycle's stimulus is applied; the readout port is compared
// against the head of the queue, and state/count/overflow after every edge.
// A second instance with POST_TRIG=0 covers the immediate-DONE case.

module tb_rvga_debugtrace_buf;

    localparam int DEPTH     = 16;
    localparam int PCW       = 32;
    localparam int POST_TRIG = 4;
`ifdef RVGA_TRACE_TIMESTAMP_EN
    localparam int RECW      = PCW + 30;
`else
    localparam int RECW      = PCW + 14;
`endif
    localparam int CNTW      = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid;
    logic [PCW-1:0]  pc;
    logic [6:0]      opcode;
    logic [2:0]      itype;
    logic [3:0]      subop;
    logic            arm;
    logic            abort;
    logic            trig_en;
    logic [6:0]      trig_op;
    logic            rd_ready;

    logic            rd_valid;
    logic [RECW-1:0] rd_data;
    logic [1:0]      state;
    logic [CNTW-1:0] count;
    logic            overflow;

    logic            p0_rd_valid;
    logic [RECW-1:0] p0_rd_data;
    logic [1:0]      p0_state;
    logic [CNTW-1:0] p0_count;
    logic            p0_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [RECW-1:0] q [$];
    logic [1:0]      m_state;
    int              m_post;
    logic            m_ovf;

    always #5 clk = ~clk;

`ifdef RVGA_TRACE_TIMESTAMP_EN
    logic [15:0] tb_ts;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= 16'd0;
        else        tb_ts <= tb_ts + 16'd1;
    end
`endif

    rvga_debugtrace_buf #(.DEPTH(DEPTH), .PCW(PCW), .POST_TRIG(POST_TRIG)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .pc_i(pc),
        .opcode_i(opcode), .inst_type_i(itype), .subop_i(subop),
        .arm_i(arm), .abort_i(abort), .trig_en_i(trig_en),
        .trig_opcode_i(trig_op), .rd_ready_i(rd_ready),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data), .state_o(state),
        .count_o(count), .overflow_o(overflow)
    );

    rvga_debugtrace_buf #(.DEPTH(DEPTH), .PCW(PCW), .POST_TRIG(0)) dut_p0 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .pc_i(pc),
        .opcode_i(opcode), .inst_type_i(itype), .subop_i(subop),
        .arm_i(arm), .abort_i(abort), .trig_en_i(trig_en),
        .trig_opcode_i(trig_op), .rd_ready_i(rd_ready),
        .rd_valid_o(p0_rd_valid), .rd_data_o(p0_rd_data), .state_o(p0_state),
        .count_o(p0_count), .overflow_o(p0_overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RECW-1:0] mk_rec();
`ifdef RVGA_TRACE_TIMESTAMP_EN
        return {pc, opcode, itype, subop, tb_ts};
`else
        return {pc, opcode, itype, subop};
`endif
    endfunction

    function automatic logic [PCW-1:0] pc_of(input int idx);
        return PCW'(32'h0000_1000 + 32'(idx) * 4);
    endfunction

    task automatic push_rec(input logic [RECW-1:0] rec);
        if (q.size() == DEPTH) begin
            void'(q.pop_front());
            m_ovf = 1'b1;
        end
        q.push_back(rec);
    endtask

    // One clock: check readout against the scoreboard, advance the model
    // with the inputs now applied, take the edge, then check the registers.
    task automatic cyc();
        logic [RECW-1:0] rec;
        if (m_state == S_DONE && q.size() != 0) begin
            chk("rd_valid", 64'(rd_valid), 64'd1);
            chk("rd_data", 64'(rd_data), 64'(q[0]));
        end else begin
            chk("rd_valid_idle", 64'(rd_valid), 64'd0);
            if (q.size() == 0) chk("rd_data_empty", 64'(rd_data), 64'd0);
        end
        rec = mk_rec();
        if (abort) begin
            q.delete();
            m_state = S_IDLE;
        end else if (arm) begin
            q.delete();
            m_ovf   = 1'b0;
            m_state = S_ARMED;
        end else begin
            case (m_state)
                S_ARMED: if (valid) begin
                    push_rec(rec);
                    if (!trig_en || opcode == trig_op) begin
                        m_post  = POST_TRIG;
                        m_state = (POST_TRIG == 0) ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: if (valid) begin
                    push_rec(rec);
                    m_post--;
                    if (m_post == 0) m_state = S_DONE;
                end
                S_DONE: if (q.size() != 0 && rd_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) m_state = S_IDLE;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        chk("state", 64'(state), 64'(m_state));
        chk("count", 64'(count), 64'(q.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic ins(input int idx, input logic [6:0] op);
        valid  = 1'b1;
        pc     = pc_of(idx);
        opcode = op;
        itype  = 3'(idx);
        subop  = 4'(idx);
        cyc();
        valid  = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, 64'(state), 64'(S_IDLE));
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    endtask

    task automatic model_reset();
        q.delete();
        m_state = S_IDLE;
        m_post  = 0;
        m_ovf   = 1'b0;
    endtask

`ifdef RVGA_TRACE_TIMESTAMP_EN
    // Two instructions five cycles apart; the model carries the timestamps
    // and the explicit check confirms the 5-cycle spacing modulo 2^16.
    task automatic ts_pair(input string tag);
        logic [15:0] ts_a;
        trig_en = 1'b0;
        pulse_arm();
        ts_a = tb_ts;
        ins(1, 7'h13);
        repeat (4) cyc();
        ins(2, 7'h13);
        for (int i = 3; i <= 5; i++) ins(i, 7'h13);
        chk({tag, "_first_ts"}, 64'(rd_data[15:0]), 64'(ts_a));
        rd_ready = 1'b1;
        cyc();
        chk({tag, "_second_ts"}, 64'(rd_data[15:0]), 64'(ts_a + 16'd5));
        repeat (5) cyc();
        rd_ready = 1'b0;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; valid = 1'b0; pc = '0; opcode = '0; itype = '0;
        subop = '0; arm = 1'b0; abort = 1'b0; trig_en = 1'b1;
        trig_op = 7'h63; rd_ready = 1'b0;
        model_reset();

        @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        cyc();

        // Opcode trigger on the 3rd instruction; DONE after the 7th.
        trig_en = 1'b1;
        trig_op = 7'h63;
        pulse_arm();
        for (int i = 1; i <= 10; i++) ins(i, (i == 3) ? 7'h63 : 7'h13);
        chk("basic_state_done", 64'(state), 64'(S_DONE));
        chk("basic_count7", 64'(count), 64'd7);
        chk("basic_first_pc", 64'(rd_data[RECW-1 -: PCW]), 64'(pc_of(1)));
        rd_ready = 1'b1;
        repeat (8) cyc();
        rd_ready = 1'b0;
        chk("basic_back_idle", 64'(state), 64'(S_IDLE));

        // Overflow: 20 + trigger + 4 = 25 records into 16 slots.
        pulse_arm();
        for (int i = 1; i <= 20; i++) ins(i, 7'h13);
        ins(21, 7'h63);
        for (int i = 22; i <= 25; i++) ins(i, 7'h13);
        chk("ovf_count16", 64'(count), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_first_pc", 64'(rd_data[RECW-1 -: PCW]), 64'(pc_of(10)));

        // Backpressure: ready toggles each cycle while draining.
        for (int k = 0; k < 36; k++) begin
            rd_ready = k[0];
            cyc();
        end
        rd_ready = 1'b0;
        chk("bp_drained_idle", 64'(state), 64'(S_IDLE));
        chk("ovf_sticky_idle", 64'(overflow), 64'd1);

        // abort in IDLE keeps the overflow flag.
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_holds_ovf", 64'(overflow), 64'd1);

        // POST_TRIG=0 instance: first instruction triggers and finishes.
        trig_en = 1'b0;
        pulse_arm();
        ins(40, 7'h13);
        chk("p0_state_done", 64'(p0_state), 64'(S_DONE));
        chk("p0_count1", 64'(p0_count), 64'd1);
        chk("p0_rd_valid", 64'(p0_rd_valid), 64'd1);
        chk("p0_overflow", 64'(p0_overflow), 64'd0);
        chk("p0_rd_pc", 64'(p0_rd_data[RECW-1 -: PCW]), 64'(pc_of(40)));
        chk("p0_rd_op", 64'(p0_rd_data[RECW-PCW-1 -: 7]), 64'(7'h13));
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        chk("p0_popped_idle", 64'(p0_state), 64'(S_IDLE));
        chk("p0_popped_count", 64'(p0_count), 64'd0);

        // Main instance is in CAPTURE now; arm and abort together -> IDLE.
        chk("pre_abort_capture", 64'(state), 64'(S_CAPTURE));
        arm = 1'b1;
        abort = 1'b1;
        cyc();
        arm = 1'b0;
        abort = 1'b0;
        chk("arm_abort_idle", 64'(state), 64'(S_IDLE));
        chk("arm_abort_count0", 64'(count), 64'd0);

        // Re-arm while ARMED with valid in the same cycle: nothing recorded.
        trig_en = 1'b1;
        pulse_arm();
        ins(50, 7'h13);
        valid = 1'b1;
        pc = pc_of(51);
        opcode = 7'h63;
        pulse_arm();
        valid = 1'b0;
        chk("rearm_drop_valid", 64'(count), 64'd0);

        // Reset in the middle of readout.
        trig_en = 1'b0;
        for (int i = 60; i <= 64; i++) ins(i, 7'h13);
        chk("pre_rst_done", 64'(state), 64'(S_DONE));
        rd_ready = 1'b1;
        cyc();
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_async");
        @(posedge clk);
        #1;
        check_reset_values("rst_held");
        rst_n = 1'b1;
        rd_ready = 1'b0;
        model_reset();
        cyc();
        check_reset_values("rst_after");

`ifdef RVGA_TRACE_TIMESTAMP_EN
        ts_pair("ts_plain");
        for (int k = 0; k < 70000 && tb_ts != 16'd65533; k++) begin
            @(posedge clk);
            #1;
        end
        ts_pair("ts_wrap");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
